rambus_arbiter: RTL

- Shares the single OpenRAM wrapper port B rambus between up to N_REQ user-project Wishbone masters. Only requesters enabled by their `active` bit are considered.
- Arbitration is round-robin with one-cycle arbitration latency. The grant is held for a whole Wishbone cycle (cyc high).
- A watchdog aborts transactions that never receive an ack.
- Sits in user_project_wrapper between the user projects' rambus_wb_* outputs and wb_openram_wrapper port B.

---
 rtl/rambus_pkg.sv | 16 +
 rtl/rambus_arbiter_rr_pick.sv | 33 +++
 rtl/rambus_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/rambus_pkg.sv
// Shared types and default widths for the rambus port-B arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rambus_pkg;

  localparam int ADR_W_DEF = 10;
  localparam int DAT_W     = 32;
  localparam int SEL_W     = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_ABORT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rambus_arbiter_rr_pick.sv
// Round-robin picker: first set request bit searching last+1, last+2, ... mod N_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] k;

  // Walk the ring starting just after the last winner; the last winner is checked last.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      k = IDX_W'((int'(last_i) + off) % N_REQ);
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/rambus_arbiter.sv
// Round-robin arbiter sharing the OpenRAM port-B Wishbone bus among N_REQ masters.
// Latency: 1 cycle request->downstream cyc/stb; ack/read data pass through combinationally.
// Backpressure: losers simply hold cyc/stb; a watchdog aborts a granted cycle that never gets ack.
module rambus_arbiter
  import rambus_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ADR_W   = ADR_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  input  logic [N_REQ-1:0]       req_en_i,
  input  logic [N_REQ-1:0]       req_cyc_i,
  input  logic [N_REQ-1:0]       req_stb_i,
  input  logic [N_REQ-1:0]       req_we_i,
  input  logic [SEL_W*N_REQ-1:0] req_sel_i,
  input  logic [ADR_W*N_REQ-1:0] req_adr_i,
  input  logic [DAT_W*N_REQ-1:0] req_dat_i,
  output logic [N_REQ-1:0]       req_ack_o,
  output logic [N_REQ-1:0]       req_err_o,
  output logic [DAT_W-1:0]       req_dat_o,
  output logic                   rambus_wb_clk_o,
  output logic                   rambus_wb_rst_o,
  output logic                   rambus_wb_cyc_o,
  output logic                   rambus_wb_stb_o,
  output logic                   rambus_wb_we_o,
  output logic [SEL_W-1:0]       rambus_wb_sel_o,
  output logic [ADR_W-1:0]       rambus_wb_adr_o,
  output logic [DAT_W-1:0]       rambus_wb_dat_o,
  input  logic                   rambus_wb_ack_i,
  input  logic [DAT_W-1:0]       rambus_wb_dat_i,
  output logic [N_REQ-1:0]       grant_o,
  output logic [7:0]             timeout_cnt_o
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] err_q, err_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [7:0]       wd_q, wd_d;
  logic [7:0]       tcnt_q, tcnt_d;
  logic [7:0]       wd_inc;

  logic [N_REQ-1:0] req_vld;
  logic [N_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  logic             busy;
  logic             g_cyc;
  logic             g_stb;

  logic [SEL_W-1:0] sel_a [N_REQ];
  logic [ADR_W-1:0] adr_a [N_REQ];
  logic [DAT_W-1:0] dat_a [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign sel_a[g] = req_sel_i[g*SEL_W +: SEL_W];
    assign adr_a[g] = req_adr_i[g*ADR_W +: ADR_W];
    assign dat_a[g] = req_dat_i[g*DAT_W +: DAT_W];
  end

  assign req_vld = req_en_i & req_cyc_i & req_stb_i;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i  (req_vld),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // While BUSY, last_q holds the granted index, so it doubles as the mux select.
  assign busy  = (state_q == ARB_BUSY);
  assign g_cyc = busy & req_en_i[last_q] & req_cyc_i[last_q];
  assign g_stb = busy & req_en_i[last_q] & req_stb_i[last_q];

  assign rambus_wb_clk_o = wb_clk_i;
  assign rambus_wb_rst_o = ~wb_rst_ni;
  assign rambus_wb_cyc_o = g_cyc;
  assign rambus_wb_stb_o = g_stb;
  assign rambus_wb_we_o  = busy & req_we_i[last_q];
  assign rambus_wb_sel_o = busy ? sel_a[last_q] : '0;
  assign rambus_wb_adr_o = busy ? adr_a[last_q] : '0;
  assign rambus_wb_dat_o = busy ? dat_a[last_q] : '0;

  assign req_ack_o     = grant_q & {N_REQ{busy & rambus_wb_ack_i}};
  assign req_err_o     = err_q;
  assign req_dat_o     = rambus_wb_dat_i;
  assign grant_o       = grant_q;
  assign timeout_cnt_o = tcnt_q;
  assign wd_inc        = wd_q + 8'd1;

  // Next-state: arbitrate in IDLE, track release and watchdog in BUSY, one dead cycle in ABORT.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wd_d    = wd_q;
    tcnt_d  = tcnt_q;
    err_d   = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d = ARB_BUSY;
          grant_d = pick_gnt;
          last_d  = pick_idx;
          wd_d    = '0;
        end
      end
      ARB_BUSY: begin
        if (!g_cyc) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          wd_d    = '0;
        end else if (rambus_wb_ack_i || !g_stb) begin
          // An ack in the would-be timeout cycle wins over the abort.
          wd_d = '0;
        end else if (wd_inc == 8'(TIMEOUT)) begin
          state_d = ARB_ABORT;
          grant_d = '0;
          wd_d    = '0;
          err_d   = grant_q;
          if (tcnt_q != 8'hFF) begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end else begin
          wd_d = wd_inc;
        end
      end
      ARB_ABORT: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers; reset makes the next search start at requester 0.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      err_q   <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      wd_q    <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      err_q   <= err_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      tcnt_q  <= tcnt_d;
    end
  end

endmodule
